uart_tx_arbiter: RTL

//  Shares one uart_tx transmitter between N_REQ byte producers. Round-robin pick among

---
 rtl/uart_tx_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among N_REQ byte producers.
// Optional frame watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic               clk,
    input  logic               arst,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic               busy,
    output logic               uart_send,
    output logic [7:0]         uart_data,
    input  logic               uart_tx_active,
    input  logic               uart_tx_done,
    output logic               err_timeout
);

    localparam int PW = $clog2(N_REQ);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, START, BUSY, GAP} state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   winner;
    logic [PW-1:0]   idx;
    logic            found;
    logic [GW-1:0]   gap_cnt;
    logic            wd_hit;

    logic act_m, act_s, act_d;
    logic done_m, done_s, done_d;
    logic act_rise, act_fall, done_rise;

    // uart_tx status comes from the baud domain: two flops, then one more for edges
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            act_m  <= 1'b0;
            act_s  <= 1'b0;
            act_d  <= 1'b0;
            done_m <= 1'b0;
            done_s <= 1'b0;
            done_d <= 1'b0;
        end else begin
            act_m  <= uart_tx_active;
            act_s  <= act_m;
            act_d  <= act_s;
            done_m <= uart_tx_done;
            done_s <= done_m;
            done_d <= done_s;
        end
    end

    assign act_rise  = act_s & ~act_d;
    assign act_fall  = ~act_s & act_d;
    assign done_rise = done_s & ~done_d;

    // Scan starts just after the last winner, so it has lowest priority next round
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = PW'((int'(ptr) + i) % N_REQ);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    logic [31:0] wd_cnt;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wd_cnt <= '0;
        end else if (state == START || state == BUSY) begin
            wd_cnt <= wd_cnt + 32'd1;
        end else begin
            wd_cnt <= '0;
        end
    end

    assign wd_hit = (state == START || state == BUSY) &&
                    (wd_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT_CYCLES;
    assign wd_hit     = 1'b0;
`endif

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state       <= IDLE;
            ptr         <= PW'(N_REQ - 1);
            gnt         <= '0;
            done        <= '0;
            uart_send   <= 1'b0;
            uart_data   <= 8'h00;
            gap_cnt     <= '0;
            err_timeout <= 1'b0;
        end else begin
            gnt         <= '0;
            done        <= '0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        uart_data <= req_data[{winner, 3'b000} +: 8];
                        gnt       <= N_REQ'(1) << winner;
                        ptr       <= winner;
                        state     <= START;
                    end
                end
                START: begin
                    if (wd_hit) begin
                        err_timeout <= 1'b1;
                        uart_send   <= 1'b0;
                        gap_cnt     <= '0;
                        state       <= GAP;
                    end else if (act_rise && done_rise) begin
                        // frame shorter than the synchroniser delay
                        done      <= N_REQ'(1) << ptr;
                        uart_send <= 1'b0;
                        gap_cnt   <= '0;
                        state     <= GAP;
                    end else if (act_rise) begin
                        uart_send <= 1'b0;
                        state     <= BUSY;
                    end else begin
                        uart_send <= 1'b1;
                    end
                end
                BUSY: begin
                    uart_send <= 1'b0;
                    if (wd_hit) begin
                        err_timeout <= 1'b1;
                        gap_cnt     <= '0;
                        state       <= GAP;
                    end else if (done_rise || act_fall) begin
                        done    <= N_REQ'(1) << ptr;
                        gap_cnt <= '0;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule
